// File: rtl/minterm_pkg.sv
// minterm_pkg: shared states and default sizing for the minterm capture reader
package minterm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;
  localparam int N_DEF = 4;
  localparam int SETTLE_DEF = 1;
  function automatic int mask_w(input int n);
    return 1 << n;
  endfunction
  localparam int MASK_W = mask_w(N_DEF);
endpackage

// File: rtl/minterm_capture_settle_timer.sv
// settle_timer: counts hold cycles for one input vector; hit on the last one
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign hit = cnt == CW'(SETTLE - 1);
endmodule

// File: rtl/minterm_capture.sv
// minterm_capture: sweeps abcd through every input vector and records y into mask; MINTERM_CMP_EN adds reference compare
module minterm_capture
  import minterm_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                y,
  output logic [N-1:0]        abcd,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   mask
`ifdef MINTERM_CMP_EN
  ,
  input  logic [(1<<N)-1:0]   expected,
  output logic                match,
  output logic [N-1:0]        err_idx
`endif
);
  state_t state, state_n;
  logic [N-1:0] idx;
  logic hit, accept, last;
  assign accept = state == IDLE && start;
  assign last = idx == '1;
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept || state == SAMPLE),
    .en (state == WAIT),
    .hit(hit)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? WAIT : IDLE;
      WAIT:    state_n = hit ? SAMPLE : WAIT;
      SAMPLE:  state_n = last ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      mask <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        idx <= '0;
        mask <= '0;
      end else if (state == SAMPLE) begin
        mask[idx] <= y;
        if (!last) idx <= idx + 1'b1;
      end
    end
  assign abcd = idx;
  assign busy = state == WAIT || state == SAMPLE;
  assign done = state == DONE;
`ifdef MINTERM_CMP_EN
  logic mismatch;
  // only the first disagreement is kept, so err_idx is the lowest failing vector
  always_ff @(posedge clk)
    if (rst || accept) begin
      mismatch <= 1'b0;
      match <= 1'b0;
      err_idx <= '0;
    end else if (state == SAMPLE && y != expected[idx] && !mismatch) begin
      mismatch <= 1'b1;
      err_idx <= idx;
    end else if (state == DONE) match <= ~mismatch;
`endif
endmodule

// File: tb/tb_minterm_capture.sv
// tb_minterm_capture: randomized scoreboard bench for minterm_capture (N=4, SETTLE=1)
module tb_minterm_capture;
  logic clk = 0, rst = 1, start = 0, y;
  logic [3:0] abcd;
  logic busy, done;
  logic [15:0] mask;
  logic [15:0] tbl = '0;
  bit use_sop = 0;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {logic [15:0] m; int st;} exp_t;
  exp_t q[$];
`ifdef MINTERM_CMP_EN
  logic [15:0] exp_in = '0;
  logic match;
  logic [3:0] err_idx;
  bit cmp_pend = 0;
  logic cmp_match;
  logic [3:0] cmp_err;
`endif

  minterm_capture #(.N(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .abcd(abcd), .busy(busy), .done(done), .mask(mask)
`ifdef MINTERM_CMP_EN
    , .expected(exp_in), .match(match), .err_idx(err_idx)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Y1 gate cell: A'B + AB'CD + ABC'
  function automatic logic y1(input logic [3:0] v);
    return (!v[3] && v[2]) || (v[3] && !v[2] && v[1] && v[0]) || (v[3] && v[2] && !v[1]);
  endfunction
  always_comb y = use_sop ? y1(abcd) : tbl[abcd];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    int d;
    exp_t e;
    if (!rst) begin
`ifdef MINTERM_CMP_EN
      if (cmp_pend) begin
        chk("match", match, cmp_match);
        chk("err_idx", err_idx, cmp_err);
        cmp_pend = 0;
      end
`endif
      if (q.size() > 0) begin
        d = cyc - q[0].st;
        if (d >= 1 && d <= 32) begin
          chk("busy_in_sweep", busy, 1);
          chk("abcd_step", abcd, (d - 1) / 2);
        end
      end
      if (done) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("mask", mask, e.m);
          chk("done_cycle", cyc, e.st + 33);
          chk("busy_in_done", busy, 0);
`ifdef MINTERM_CMP_EN
          cmp_match = (e.m == exp_in);
          cmp_err = 0;
          for (int i = 15; i >= 0; i--) if (e.m[i] != exp_in[i]) cmp_err = 4'(i);
          cmp_pend = 1;
`endif
        end
      end
    end
  end

  task automatic sweep(input logic [15:0] m);
    @(negedge clk);
    start = 1;
    q.push_back('{m, cyc});
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() > 0) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_abcd(input logic [3:0] v);
    int n = 0;
    while (abcd !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_abcd", abcd, v);
  endtask

  initial begin
    logic [15:0] last_m;
    repeat (3) @(negedge clk);
    chk("rst_abcd", abcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mask", mask, 0);
    rst = 0;
    // y tied low, then high
    tbl = 16'h0000;
    sweep(16'h0000);
    wait_idle();
    chk("idle_busy", busy, 0);
    chk("idle_abcd", abcd, 15);
    tbl = 16'hFFFF;
    sweep(16'hFFFF);
    wait_idle();
    chk("hold_mask", mask, 16'hFFFF);
    // Y1 cell
    use_sop = 1;
    sweep(16'h38F0);
    wait_idle();
    // reset mid-sweep
    sweep(16'h38F0);
    wait_abcd(4'd5);
    rst = 1;
    q.delete();
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_mask", mask, 0);
    chk("abort_abcd", abcd, 0);
    chk("abort_done", done, 0);
    repeat (5) @(negedge clk);
    sweep(16'h38F0);
    wait_idle();
    // starts during a sweep and during DONE are ignored
    sweep(16'h38F0);
    wait_abcd(4'd3);
    start = 1;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 100 && !done; n++) @(negedge clk);
    chk("done_seen", done, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (40) @(negedge clk);
    chk("no_extra_busy", busy, 0);
    // start held high re-triggers the cycle after DONE
    use_sop = 0;
    tbl = 16'hA5C3;
    @(negedge clk);
    start = 1;
    q.push_back('{16'hA5C3, cyc});
    q.push_back('{16'hA5C3, cyc + 34});
    repeat (40) @(negedge clk);
    start = 0;
    wait_idle();
    // random truth tables
    for (int k = 0; k < 4; k++) begin
      tbl = 16'($urandom);
      last_m = tbl;
      sweep(last_m);
      wait_idle();
      chk("rand_hold_mask", mask, last_m);
    end
`ifdef MINTERM_CMP_EN
    use_sop = 1;
    exp_in = 16'h38F0;
    sweep(16'h38F0);
    wait_idle();
    exp_in = 16'h38F1;
    sweep(16'h38F0);
    wait_idle();
    exp_in = 16'hB8F0;
    sweep(16'h38F0);
    wait_idle();
    exp_in = 16'($urandom);
    sweep(16'h38F0);
    wait_idle();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
